// File: rtl/aes_round0_keybank_pipe.sv
// Round-0 AddRoundKey stage: per-block key selection from a bank of encrypt/inverse
// key slots, loaded-flag checking, and a small registered output FIFO.
module aes_round0_keybank_pipe #(
  parameter int DATA_W    = 128,
  parameter int NUM_KEYS  = 4,
  parameter int IDX_W     = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
  parameter int OUT_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_wr_en,
  input  logic              key_wr_inv,
  input  logic [IDX_W-1:0]  key_wr_idx,
  input  logic [DATA_W-1:0] key_wr_data,
  input  logic              key_clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_en_de,
  input  logic [IDX_W-1:0]  in_key_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_en_de,
  output logic [IDX_W-1:0]  out_key_idx,
  output logic              out_err
);

  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam logic [IDX_W:0]     NUM_KEYS_C = (IDX_W + 1)'(NUM_KEYS);
  localparam logic [CNT_W-1:0]   DEPTH_C    = CNT_W'(OUT_DEPTH);
  localparam logic [PTR_W-1:0]   LAST_PTR   = PTR_W'(OUT_DEPTH - 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              en_de;
    logic [IDX_W-1:0]  key_idx;
    logic              err;
  } entry_t;

  logic [DATA_W-1:0] enc_key [NUM_KEYS];
  logic [DATA_W-1:0] inv_key [NUM_KEYS];
  logic [NUM_KEYS-1:0] enc_ld;
  logic [NUM_KEYS-1:0] inv_ld;

  entry_t            mem [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic   push;
  logic   pop;
  logic   sel_ok;
  logic   sel_ld;
  logic [DATA_W-1:0] sel_key;
  entry_t new_entry;
  entry_t head;

  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Reads see the bank as it stood before this edge, so a same-cycle key write
  // never leaks into the block being accepted.
  always_comb begin
    sel_ok    = ({1'b0, in_key_idx} < NUM_KEYS_C);
    sel_key   = in_en_de ? inv_key[in_key_idx] : enc_key[in_key_idx];
    sel_ld    = sel_ok && (in_en_de ? inv_ld[in_key_idx] : enc_ld[in_key_idx]);
    new_entry = '0;
    new_entry.en_de   = in_en_de;
    new_entry.key_idx = in_key_idx;
    if (sel_ld) begin
      new_entry.data = in_data ^ sel_key;
      new_entry.err  = 1'b0;
    end else begin
      new_entry.data = '0;
      new_entry.err  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the later flag write
  // for the addressed slot deliberately overrides the clear issued just before it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        enc_key[i] <= '0;
        inv_key[i] <= '0;
      end
      enc_ld <= '0;
      inv_ld <= '0;
    end else begin
      if (key_clear) begin
        enc_ld <= '0;
        inv_ld <= '0;
      end
      if (key_wr_en && ({1'b0, key_wr_idx} < NUM_KEYS_C)) begin
        if (key_wr_inv) begin
          inv_key[key_wr_idx] <= key_wr_data;
          inv_ld[key_wr_idx]  <= 1'b1;
        end else begin
          enc_key[key_wr_idx] <= key_wr_data;
          enc_ld[key_wr_idx]  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; stale contents are never visible because
  // every output field is gated by out_valid, which derives from the reset count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  assign head        = mem[rd_ptr];
  assign out_data    = out_valid ? head.data    : '0;
  assign out_en_de   = out_valid ? head.en_de   : 1'b0;
  assign out_key_idx = out_valid ? head.key_idx : '0;
  assign out_err     = out_valid ? head.err     : 1'b0;

endmodule

// File: tb/tb_aes_round0_keybank_pipe.sv
// Bench for aes_round0_keybank_pipe: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based behavioural model.
module tb_aes_round0_keybank_pipe;

  localparam int DATA_W = 128;
  localparam int NK     = 4;
  localparam int IDX_W  = 2;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              key_wr_en = 1'b0;
  logic              key_wr_inv = 1'b0;
  logic [IDX_W-1:0]  key_wr_idx = '0;
  logic [DATA_W-1:0] key_wr_data = '0;
  logic              key_clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_en_de = 1'b0;
  logic [IDX_W-1:0]  in_key_idx = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic              out_en_de;
  logic [IDX_W-1:0]  out_key_idx;
  logic              out_err;

  aes_round0_keybank_pipe #(
    .DATA_W(DATA_W), .NUM_KEYS(NK), .OUT_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .key_wr_en(key_wr_en), .key_wr_inv(key_wr_inv), .key_wr_idx(key_wr_idx),
    .key_wr_data(key_wr_data), .key_clear(key_clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_en_de(in_en_de), .in_key_idx(in_key_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_en_de(out_en_de), .out_key_idx(out_key_idx), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    bit                en_de;
    int                idx;
    bit                err;
  } ent_t;

  ent_t              mq[$];
  logic [DATA_W-1:0] m_enc [NK];
  logic [DATA_W-1:0] m_inv [NK];
  bit                m_enc_ld [NK];
  bit                m_inv_ld [NK];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < NK; i++) begin
      m_enc[i] = '0; m_inv[i] = '0; m_enc_ld[i] = 0; m_inv_ld[i] = 0;
    end
  endtask

  // Predicts the effect of the coming rising edge from the inputs now applied.
  task automatic model_update();
    bit   push, pop, ld;
    int   idx;
    ent_t e;
    push = in_valid && (mq.size() < DEPTH);
    pop  = (mq.size() > 0) && out_ready;
    idx  = int'(in_key_idx);
    e.en_de = in_en_de;
    e.idx   = idx;
    ld = (idx < NK) && (in_en_de ? m_inv_ld[idx] : m_enc_ld[idx]);
    if (ld) begin
      e.data = in_data ^ (in_en_de ? m_inv[idx] : m_enc[idx]);
      e.err  = 0;
    end else begin
      e.data = '0;
      e.err  = 1;
    end
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(e);
    if (key_clear)
      for (int i = 0; i < NK; i++) begin m_enc_ld[i] = 0; m_inv_ld[i] = 0; end
    if (key_wr_en && int'(key_wr_idx) < NK) begin
      if (key_wr_inv) begin m_inv[key_wr_idx] = key_wr_data; m_inv_ld[key_wr_idx] = 1; end
      else            begin m_enc[key_wr_idx] = key_wr_data; m_enc_ld[key_wr_idx] = 1; end
    end
  endtask

  task automatic compare();
    logic [255:0] exp;
    logic [1:0]   eidx;
    check("out_valid", 256'(out_valid), 256'(mq.size() != 0));
    check("in_ready", 256'(in_ready), 256'(mq.size() < DEPTH));
    exp = '0;
    if (mq.size() != 0) begin
      eidx = mq[0].idx[1:0];
      exp  = 256'({mq[0].data, mq[0].en_de, eidx, mq[0].err});
    end
    check("payload", 256'({out_data, out_en_de, out_key_idx, out_err}), exp);
  endtask

  task automatic idle();
    in_valid = 0; key_wr_en = 0; key_clear = 0; out_ready = 1;
  endtask

  task automatic cycle();
    model_update();
    @(posedge clk);
    @(negedge clk);
    compare();
    idle();
  endtask

  task automatic wr_key(input bit inv, input int idx, input logic [DATA_W-1:0] k);
    key_wr_en = 1; key_wr_inv = inv; key_wr_idx = IDX_W'(idx); key_wr_data = k;
  endtask

  task automatic send(input bit de, input int idx, input logic [DATA_W-1:0] d);
    in_valid = 1; in_en_de = de; in_key_idx = IDX_W'(idx); in_data = d;
  endtask

  logic [DATA_W-1:0] ka, kb, d1, d2;

  initial begin
    model_reset();
    #12;
    check("rst out_valid", 256'(out_valid), 256'(0));
    check("rst in_ready", 256'(in_ready), 256'(1));
    check("rst outputs", 256'({out_data, out_en_de, out_key_idx, out_err}), 256'(0));
    @(negedge clk);
    rst_n = 1;
    cycle();

    // Unloaded slot after reset
    send(1, 1, rnd128());
    cycle();
    check("T2 valid", 256'(out_valid), 256'(1));
    check("T2 data", 256'(out_data), 256'(0));
    check("T2 err", 256'(out_err), 256'(1));
    check("T2 idx", 256'(out_key_idx), 256'(1));
    cycle();

    // FIPS-197 round-0 vector
    wr_key(0, 0, 128'h000102030405060708090a0b0c0d0e0f);
    cycle();
    send(0, 0, 128'h00112233445566778899aabbccddeeff);
    cycle();
    check("T1 data", 256'(out_data), 256'(128'h00102030405060708090a0b0c0d0e0f0));
    check("T1 err", 256'(out_err), 256'(0));
    cycle();

    // Backpressure: third push must stall
    for (int i = 0; i < 3; i++) begin
      out_ready = 0;
      send(0, 0, rnd128());
      cycle();
      if (i == 0) check("T3 ready after 1", 256'(in_ready), 256'(1));
      if (i == 1) check("T3 ready after 2", 256'(in_ready), 256'(0));
    end
    for (int i = 0; i < 3; i++) cycle();
    check("T3 drained", 256'(out_valid), 256'(0));

    // Write/accept collision on slot 2
    ka = rnd128(); kb = rnd128(); d1 = rnd128(); d2 = rnd128();
    wr_key(0, 2, ka);
    cycle();
    wr_key(0, 2, kb);
    send(0, 2, d1);
    cycle();
    check("T4 old key", 256'(out_data), 256'(d1 ^ ka));
    send(0, 2, d2);
    cycle();
    check("T4 new key", 256'(out_data), 256'(d2 ^ kb));
    cycle();

    // key_clear with an entry queued ahead of it
    wr_key(0, 0, rnd128());
    cycle();
    wr_key(1, 0, rnd128());
    cycle();
    out_ready = 0;
    send(0, 0, rnd128());
    cycle();
    out_ready = 0;
    key_clear = 1;
    cycle();
    out_ready = 0;
    send(0, 0, rnd128());
    cycle();
    check("T5 queued err", 256'(out_err), 256'(0));
    cycle();
    check("T5 cleared err", 256'(out_err), 256'(1));
    cycle();

    // Asynchronous reset with a full buffer
    wr_key(0, 3, rnd128());
    cycle();
    for (int i = 0; i < 2; i++) begin
      out_ready = 0;
      send(0, 3, rnd128());
      cycle();
    end
    check("T6 full", 256'(in_ready), 256'(0));
    out_ready = 0;
    #2 rst_n = 0;
    #1;
    model_reset();
    check("T6 valid", 256'(out_valid), 256'(0));
    check("T6 ready", 256'(in_ready), 256'(1));
    @(negedge clk);
    rst_n = 1;
    send(0, 3, rnd128());
    cycle();
    check("T6 flag cleared", 256'(out_err), 256'(1));
    cycle();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_en_de   = $urandom_range(0, 1);
      in_key_idx = IDX_W'($urandom_range(0, NK - 1));
      in_data    = rnd128();
      out_ready  = ($urandom_range(0, 2) != 0);
      key_wr_en  = ($urandom_range(0, 3) == 0);
      key_wr_inv = $urandom_range(0, 1);
      key_wr_idx = IDX_W'($urandom_range(0, NK - 1));
      key_wr_data = rnd128();
      key_clear  = ($urandom_range(0, 39) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
